// File: rtl/quad_enc_emulator.sv
// quad_enc_emulator: turns step/dir requests into A/B quadrature edges.
// Define QUAD_ENC_EMULATOR_INDEX_EN to add the once-per-rev enc_z output.
module quad_enc_emulator #(
  parameter int PENDBITS = 16,
  parameter int POSBITS  = 32,
  parameter int CPR      = 4000
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                enable,
  input  logic                step,
  input  logic                dir,
  input  logic [15:0]         min_period,
  input  logic                clear_overflow,
  output logic                enc_a,
  output logic                enc_b,
`ifdef QUAD_ENC_EMULATOR_INDEX_EN
  output logic                enc_z,
`endif
  output logic [POSBITS-1:0]  position,
  output logic [PENDBITS-1:0] pending,
  output logic                busy,
  output logic                overflow
);

  localparam logic [PENDBITS-1:0] PEND_ONE = PENDBITS'(1);
  localparam logic [PENDBITS-1:0] PEND_MAX =
    {1'b0, {(PENDBITS-1){1'b1}}};
  localparam logic [PENDBITS-1:0] PEND_MIN =
    {1'b1, {(PENDBITS-2){1'b0}}, 1'b1};
  localparam logic [POSBITS-1:0]  POS_ONE  = POSBITS'(1);

  if (CPR < 2) begin : g_cpr_check
    $error("CPR must be at least 2");
  end

  logic [1:0]          phase;
  logic [15:0]         timer;
  logic [15:0]         eff_period;
  logic [15:0]         timer_next;
  logic                expired;
  logic                fire;
  logic                fwd;
  logic                drop;
  logic [PENDBITS-1:0] pend_req;
  logic [PENDBITS-1:0] pend_next;
  logic [1:0]          phase_next;

  // Edge decision, timer and accumulator next-state.
  always_comb begin
    eff_period = (min_period == 16'd0) ? 16'd1 : min_period;
    expired    = (timer >= eff_period);
    fire       = enable && expired && (pending != '0);
    fwd        = ~pending[PENDBITS-1];
    phase_next = fwd ? phase + 2'd1 : phase - 2'd1;
    drop       = step && (dir ? (pending == PEND_MAX)
                              : (pending == PEND_MIN));
    pend_req   = pending;
    if (step && !drop) begin
      pend_req = dir ? pending + PEND_ONE : pending - PEND_ONE;
    end
    pend_next = pend_req;
    if (fire) begin
      pend_next = fwd ? pend_req - PEND_ONE : pend_req + PEND_ONE;
    end
    timer_next = timer + 16'd1;
    if (fire) begin
      timer_next = 16'd1;
    end else if (expired) begin
      timer_next = eff_period;
    end
  end

  // Registered phase, outputs, position and accumulator.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      phase    <= 2'd0;
      enc_a    <= 1'b0;
      enc_b    <= 1'b0;
      position <= '0;
      pending  <= '0;
      timer    <= 16'd0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      timer   <= timer_next;
      pending <= pend_next;
      busy    <= (pend_next != '0);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
      if (fire) begin
        phase    <= phase_next;
        enc_a    <= phase_next[1] ^ phase_next[0];
        enc_b    <= phase_next[1];
        position <= fwd ? position + POS_ONE : position - POS_ONE;
      end
    end
  end

`ifdef QUAD_ENC_EMULATOR_INDEX_EN
  localparam int IW = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(CPR - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [IW-1:0] idx_pos;
  logic [IW-1:0] idx_next;

  // Index position one step in the edge direction, wrapping at CPR.
  always_comb begin
    if (fwd) begin
      idx_next = (idx_pos == IDX_LAST) ? '0 : idx_pos + IDX_ONE;
    end else begin
      idx_next = (idx_pos == '0) ? IDX_LAST : idx_pos - IDX_ONE;
    end
  end

  // Index counter and registered Z pulse.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      idx_pos <= '0;
      enc_z   <= 1'b1;
    end else if (fire) begin
      idx_pos <= idx_next;
      enc_z   <= (idx_next == '0);
    end
  end
`endif

endmodule

// File: tb/tb_quad_enc_emulator.sv
// tb_quad_enc_emulator: directed table vectors plus corner sequences.
// Runs with PENDBITS=4 and CPR=8 so saturation and index wrap are short.
module tb_quad_enc_emulator;

  logic        CLK;
  logic        resetn;
  logic        enable;
  logic        step;
  logic        dir;
  logic [15:0] min_period;
  logic        clear_overflow;
  logic        enc_a;
  logic        enc_b;
`ifdef QUAD_ENC_EMULATOR_INDEX_EN
  logic        enc_z;
`endif
  logic [31:0] position;
  logic [3:0]  pending;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  quad_enc_emulator #(
    .PENDBITS(4),
    .POSBITS(32),
    .CPR(8)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .enable(enable),
    .step(step),
    .dir(dir),
    .min_period(min_period),
    .clear_overflow(clear_overflow),
    .enc_a(enc_a),
    .enc_b(enc_b),
`ifdef QUAD_ENC_EMULATOR_INDEX_EN
    .enc_z(enc_z),
`endif
    .position(position),
    .pending(pending),
    .busy(busy),
    .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        stp;
    logic        dr;
    logic [15:0] mp;
    logic [1:0]  ab;
    logic [31:0] pos;
    logic [3:0]  pend;
    logic        bsy;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic en,
                     input logic stp, input logic dr,
                     input logic [15:0] mp, input logic [1:0] ab,
                     input logic [31:0] pos, input logic [3:0] pend,
                     input logic bsy, input logic ovf);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.stp = stp; v.dr = dr; v.mp = mp;
    v.ab = ab; v.pos = pos; v.pend = pend; v.bsy = bsy; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    step = 1'b0;
    clear_overflow = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic wait_pos(input logic [31:0] want, input string nm);
    int n;
    n = 0;
    while (position !== want && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 64'(position), 64'(want));
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] cur;
    int edges;

    resetn = 1'b0; enable = 1'b0; step = 1'b0; dir = 1'b0;
    min_period = 16'd4; clear_overflow = 1'b0;

    // forward burst, period 4: edges 4 cycles apart
    add(0,1,0,1,4, 2'b00, 32'd0, 4'd0, 0,0);
    add(1,1,1,1,4, 2'b00, 32'd0, 4'd1, 1,0);
    add(1,1,1,1,4, 2'b00, 32'd0, 4'd2, 1,0);
    add(1,1,1,1,4, 2'b00, 32'd0, 4'd3, 1,0);
    add(1,1,0,1,4, 2'b00, 32'd0, 4'd3, 1,0);
    add(1,1,0,1,4, 2'b10, 32'd1, 4'd2, 1,0);
    add(1,1,0,1,4, 2'b10, 32'd1, 4'd2, 1,0);
    add(1,1,0,1,4, 2'b10, 32'd1, 4'd2, 1,0);
    add(1,1,0,1,4, 2'b10, 32'd1, 4'd2, 1,0);
    add(1,1,0,1,4, 2'b11, 32'd2, 4'd1, 1,0);
    add(1,1,0,1,4, 2'b11, 32'd2, 4'd1, 1,0);
    add(1,1,0,1,4, 2'b11, 32'd2, 4'd1, 1,0);
    add(1,1,0,1,4, 2'b11, 32'd2, 4'd1, 1,0);
    add(1,1,0,1,4, 2'b01, 32'd3, 4'd0, 0,0);
    add(1,1,0,1,4, 2'b01, 32'd3, 4'd0, 0,0);
    // reverse from reset, period 2
    add(0,1,0,0,2, 2'b00, 32'd0, 4'd0, 0,0);
    add(1,1,1,0,2, 2'b00, 32'd0, 4'hF, 1,0);
    add(1,1,1,0,2, 2'b00, 32'd0, 4'hE, 1,0);
    add(1,1,0,0,2, 2'b01, 32'hFFFF_FFFF, 4'hF, 1,0);
    add(1,1,0,0,2, 2'b01, 32'hFFFF_FFFF, 4'hF, 1,0);
    add(1,1,0,0,2, 2'b11, 32'hFFFF_FFFE, 4'h0, 0,0);
    add(1,1,0,0,2, 2'b11, 32'hFFFF_FFFE, 4'h0, 0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      resetn = vecs[i].rst_n;
      enable = vecs[i].en;
      step = vecs[i].stp;
      dir = vecs[i].dr;
      min_period = vecs[i].mp;
      tick();
      chk($sformatf("v%0d_ab", i), 64'({enc_a, enc_b}), 64'(vecs[i].ab));
      chk($sformatf("v%0d_pos", i), 64'(position), 64'(vecs[i].pos));
      chk($sformatf("v%0d_pend", i), 64'(pending), 64'(vecs[i].pend));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
    end

    // request and consume in the same cycle net to zero change
    min_period = 16'd2; enable = 1'b1;
    do_reset();
    step = 1'b1; dir = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0;
    chk("simul_pend", 64'(pending), 64'd1);
    chk("simul_pos1", 64'(position), 64'd1);
    chk("simul_ab1", 64'({enc_a, enc_b}), 64'(2'b10));
    tick(); tick();
    chk("simul_pos2", 64'(position), 64'd2);
    chk("simul_pend0", 64'(pending), 64'd0);
    tick(); tick(); tick();
    chk("simul_hold", 64'(position), 64'd2);

    // saturation at +7 with enable low
    do_reset();
    enable = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step = 1'b1; dir = 1'b1; tick();
      if (k == 7) begin
        chk("sat_pend7", 64'(pending), 64'd7);
        chk("sat_ovf_pre", 64'(overflow), 64'd0);
      end
    end
    chk("sat_pend", 64'(pending), 64'd7);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_noedge", 64'({enc_a, enc_b}), 64'(2'b00));
    clear_overflow = 1'b1; tick();
    chk("sat_set_wins", 64'(overflow), 64'd1);
    step = 1'b0; tick();
    clear_overflow = 1'b0;
    chk("sat_cleared", 64'(overflow), 64'd0);
    enable = 1'b1;
    edges = 0;
    prev = {enc_a, enc_b};
    for (int c = 0; c < 30; c++) begin
      tick();
      cur = {enc_a, enc_b};
      if (cur != prev) begin
        edges++;
        chk("sat_one_bit", 64'($countones(cur ^ prev)), 64'd1);
      end
      prev = cur;
    end
    chk("sat_edges", 64'(edges), 64'd7);
    chk("sat_pos", 64'(position), 64'd7);
    chk("sat_pend_end", 64'(pending), 64'd0);
    chk("sat_busy_end", 64'(busy), 64'd0);

    // reset in the middle of a burst
    min_period = 16'd3;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step = 1'b1; dir = 1'b1; tick();
    end
    step = 1'b0;
    chk("mid_pend", 64'(pending), 64'd5);
    chk("mid_pos", 64'(position), 64'd1);
    resetn = 1'b0; tick();
    chk("mid_rst_ab", 64'({enc_a, enc_b}), 64'(2'b00));
    chk("mid_rst_pos", 64'(position), 64'd0);
    chk("mid_rst_pend", 64'(pending), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    step = 1'b1; tick();
    step = 1'b0;
    chk("mid_wait1", 64'({enc_a, enc_b}), 64'(2'b00));
    tick();
    chk("mid_wait2", 64'({enc_a, enc_b}), 64'(2'b00));
    tick();
    chk("mid_wait3", 64'({enc_a, enc_b}), 64'(2'b00));
    tick();
    chk("mid_first_edge", 64'({enc_a, enc_b}), 64'(2'b10));

`ifdef QUAD_ENC_EMULATOR_INDEX_EN
    // index pulse over one revolution of 8 counts
    min_period = 16'd1;
    do_reset();
    chk("idx_reset", 64'(enc_z), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step = 1'b1; dir = 1'b1; tick();
      step = 1'b0;
      wait_pos(32'(k), $sformatf("idx_pos%0d", k));
      chk($sformatf("idx_z%0d", k), 64'(enc_z), 64'(k == 8));
    end
    step = 1'b1; dir = 1'b0; tick();
    step = 1'b0;
    wait_pos(32'd7, "idx_back");
    chk("idx_z_back", 64'(enc_z), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
